// File: rtl/enigma_frame_buffer.sv
// enigma_frame_buffer: captures one frame of host plaintext symbols, streams
// them through the enigma core, writes the encoded symbols back in place and
// then streams the finished frame out with a last marker.
// Status pulses (wrg_symb_o, cfg_err_o, unexp_enc_o) are registered and so
// appear the cycle after the offending input.
module enigma_frame_buffer #(
   parameter int  SYMB_W   = 7,
   parameter int  DEPTH    = 128,
   parameter int  ALPH_MIN = 1,
   parameter int  ALPH_MAX = 26,
   localparam int LEN_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [LEN_W-1:0]  frame_len_i,
   input  logic [SYMB_W-1:0] symb_i,
   input  logic              symb_val_i,
   output logic              symb_rdy_o,
   output logic [SYMB_W-1:0] en_o,
   output logic              en_val_o,
   input  logic              en_rdy_i,
   input  logic [SYMB_W-1:0] enc_i,
   input  logic              enc_val_i,
   output logic [SYMB_W-1:0] wrap_o,
   output logic              wrap_val_o,
   input  logic              wrap_rdy_i,
   output logic              wrap_last_o,
   output logic              busy_o,
   output logic              wrg_symb_o,
   output logic              cfg_err_o,
   output logic              unexp_enc_o
);
   localparam int                ADDR_W  = $clog2(DEPTH);
   localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);
   localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(DEPTH);
   localparam logic [SYMB_W-1:0] SYM_LO  = SYMB_W'(ALPH_MIN);
   localparam logic [SYMB_W-1:0] SYM_HI  = SYMB_W'(ALPH_MAX);

   typedef enum logic [1:0] {IDLE, LOAD, PROC, OUT} state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LEN_W-1:0]  wb_ptr_q, wb_ptr_d;
   logic [LEN_W-1:0]  outst_q, outst_d;
   logic [LEN_W-1:0]  done_q, done_d;
   logic              symb_rdy_q, symb_rdy_d;
   logic              wrg_q, wrg_d;
   logic              cfg_q, cfg_d;
   logic              unexp_q, unexp_d;
   logic              inflight_q, inflight_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [SYMB_W-1:0] skid0_q, skid0_d;
   logic [SYMB_W-1:0] skid1_q, skid1_d;

   logic [SYMB_W-1:0] mem [DEPTH];
   logic [SYMB_W-1:0] rdata_q;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [SYMB_W-1:0] mem_wdata;

   logic              symb_offer, symb_legal, len_ok;
   logic              stream_on, pop, rd_issue, en_hs, enc_ok;
   logic [1:0]        occ;

   assign symb_offer = symb_val_i && symb_rdy_q;
   assign symb_legal = (symb_i >= SYM_LO) && (symb_i <= SYM_HI);
   assign len_ok     = (frame_len_i != '0) && (frame_len_i <= LEN_MAX);

   // The same prefetch/skid path feeds the core in PROC and the host in OUT.
   // A read is only issued when the skid is guaranteed room for its data.
   assign stream_on = (state_q == PROC) || (state_q == OUT);
   assign pop       = stream_on && (cnt_q != 2'd0) &&
                      ((state_q == PROC) ? en_rdy_i : wrap_rdy_i);
   assign occ       = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
   assign rd_issue  = stream_on && (rd_ptr_q < len_q) && (occ <= 2'd1);
   assign en_hs     = pop && (state_q == PROC);
   assign enc_ok    = enc_val_i && (state_q == PROC) && ((outst_q != '0) || en_hs);

   assign symb_rdy_o  = symb_rdy_q;
   assign busy_o      = (state_q != IDLE);
   assign en_o        = skid0_q;
   assign en_val_o    = (state_q == PROC) && (cnt_q != 2'd0);
   assign wrap_o      = skid0_q;
   assign wrap_val_o  = (state_q == OUT) && (cnt_q != 2'd0);
   assign wrap_last_o = wrap_val_o && (done_q == len_q - LEN_ONE);
   assign wrg_symb_o  = wrg_q;
   assign cfg_err_o   = cfg_q;
   assign unexp_enc_o = unexp_q;

   // Frame buffer: one write port, registered read port (contents never reset).
   always_ff @(posedge clk_i) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      if (rd_issue) rdata_q <= mem[rd_ptr_q[ADDR_W-1:0]];
   end

   // Two-entry skid: skid0 is the registered head presented on en_o / wrap_o.
   always_comb begin
      skid0_d = skid0_q;
      skid1_d = skid1_q;
      cnt_d   = occ;
      case ({inflight_q, pop})
         2'b10: begin
            if (cnt_q == 2'd0) skid0_d = rdata_q;
            else               skid1_d = rdata_q;
         end
         2'b01: skid0_d = skid1_q;
         2'b11: begin
            if (cnt_q == 2'd1) begin
               skid0_d = rdata_q;
            end else begin
               skid0_d = skid1_q;
               skid1_d = rdata_q;
            end
         end
         default: ;
      endcase
   end

   // Frame sequencing: capture, core round trip with write-back, read-out.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      wr_ptr_d   = wr_ptr_q;
      wb_ptr_d   = wb_ptr_q;
      done_d     = pop ? done_q + LEN_ONE : done_q;
      rd_ptr_d   = rd_issue ? rd_ptr_q + LEN_ONE : rd_ptr_q;
      outst_d    = outst_q + {{(LEN_W-1){1'b0}}, en_hs} - {{(LEN_W-1){1'b0}}, enc_ok};
      inflight_d = rd_issue;
      wrg_d      = symb_offer && !symb_legal;
      cfg_d      = 1'b0;
      unexp_d    = enc_val_i && !enc_ok;
      mem_we     = 1'b0;
      mem_waddr  = '0;
      mem_wdata  = symb_i;
      case (state_q)
         IDLE: begin
            if (symb_offer && symb_legal) begin
               if (len_ok) begin
                  len_d    = frame_len_i;
                  mem_we   = 1'b1;
                  wr_ptr_d = LEN_ONE;
                  state_d  = (frame_len_i == LEN_ONE) ? PROC : LOAD;
               end else begin
                  cfg_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (symb_offer && symb_legal) begin
               mem_we    = 1'b1;
               mem_waddr = wr_ptr_q[ADDR_W-1:0];
               wr_ptr_d  = wr_ptr_q + LEN_ONE;
               if (wr_ptr_q == len_q - LEN_ONE) state_d = PROC;
            end
         end
         PROC: begin
            if (enc_ok) begin
               mem_we    = 1'b1;
               mem_waddr = wb_ptr_q[ADDR_W-1:0];
               mem_wdata = enc_i;
               wb_ptr_d  = wb_ptr_q + LEN_ONE;
            end
            // Everything fed has come back; restart the stream for read-out.
            if (wb_ptr_q == len_q) begin
               state_d  = OUT;
               rd_ptr_d = '0;
               done_d   = '0;
            end
         end
         OUT: begin
            if (pop && (done_q == len_q - LEN_ONE)) begin
               state_d  = IDLE;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               wb_ptr_d = '0;
               done_d   = '0;
               outst_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      symb_rdy_d = (state_d == IDLE) || (state_d == LOAD);
   end

   // State and control registers; reset aborts any frame in flight.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         len_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         wb_ptr_q   <= '0;
         outst_q    <= '0;
         done_q     <= '0;
         symb_rdy_q <= 1'b0;
         wrg_q      <= 1'b0;
         cfg_q      <= 1'b0;
         unexp_q    <= 1'b0;
         inflight_q <= 1'b0;
         cnt_q      <= 2'd0;
         skid0_q    <= '0;
         skid1_q    <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         wb_ptr_q   <= wb_ptr_d;
         outst_q    <= outst_d;
         done_q     <= done_d;
         symb_rdy_q <= symb_rdy_d;
         wrg_q      <= wrg_d;
         cfg_q      <= cfg_d;
         unexp_q    <= unexp_d;
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
         skid0_q    <= skid0_d;
         skid1_q    <= skid1_d;
      end
   end
endmodule
